// File: rtl/key_pkg.sv
// Shared types and constants for the key conditioner.
// Holds the channel FSM state encoding, counter widths and key bit positions.
package key_pkg;

    // Counter widths cover the full legal parameter ranges.
    localparam int unsigned DEB_W = 24;
    localparam int unsigned REP_W = 28;

    // Default channel count and bit position of each key in the key vectors.
    localparam int unsigned N_KEYS_DEFAULT = 5;
    localparam int unsigned KEY_ROTATE     = 0;
    localparam int unsigned KEY_LEFT       = 1;
    localparam int unsigned KEY_RIGHT      = 2;
    localparam int unsigned KEY_DOWN       = 3;
    localparam int unsigned KEY_PAUSE      = 4;

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_HELD_DELAY = 2'd1,
        ST_REPEATING  = 2'd2
    } key_state_e;

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus between the push-button pins and the conditioned key outputs.
//   Key_Raw    : raw asynchronous button levels, 1 = pressed
//   Key_Level  : debounced level
//   Key_Event  : one-cycle pulse per accepted press or repeat
//   Key_Repeat : high together with Key_Event when the pulse is a repeat
// master = button/stimulus side, slave = conditioner side.
interface key_conditioner_if
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS = N_KEYS_DEFAULT
);

    logic [N_KEYS-1:0] Key_Raw;
    logic [N_KEYS-1:0] Key_Level;
    logic [N_KEYS-1:0] Key_Event;
    logic [N_KEYS-1:0] Key_Repeat;

    modport master (
        output Key_Raw,
        input  Key_Level,
        input  Key_Event,
        input  Key_Repeat
    );

    modport slave (
        input  Key_Raw,
        output Key_Level,
        output Key_Event,
        output Key_Repeat
    );

endinterface

// File: rtl/key_channel.sv
// One key channel: 2-flop synchronizer, debouncer and press/repeat FSM.
// Optional feature macro: KEY_AUTOREPEAT_EN (adds the repeat counter and the
// REPEATING state; without it only press events are produced).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw         : raw asynchronous button level
//   key_level   : debounced level (registered)
//   key_event   : one-cycle press/repeat pulse (registered)
//   key_repeat  : marks key_event as a repeat (registered, 0 without repeat)
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          REPEAT_EN       = 1'b0
`endif
)(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic key_level,
    output logic key_event,
    output logic key_repeat
);

    // Counter value on which the next increment would reach DEBOUNCE_CYCLES.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             level_d;
    logic             rise_c;
    logic             fall_c;
    key_state_e       state_q;
    key_state_e       state_d;
    logic             event_d;

    // Raw pin synchronizer; the only sampler of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: count disagreeing cycles, flip the level when the count is reached.
    always_comb begin
        level_d   = key_level;
        deb_cnt_d = '0;
        if (sync_q2 != key_level) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = ~key_level;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Level edges as they will appear on the next clock edge.
    assign rise_c = level_d & ~key_level;
    assign fall_c = ~level_d & key_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            key_level <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            key_level <= level_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic             repeat_d;

    // Press/repeat FSM; release has priority so a repeat due on the release edge is dropped.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        event_d   = 1'b0;
        repeat_d  = 1'b0;
        if (fall_c) begin
            state_d   = ST_RELEASED;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    if (rise_c) begin
                        state_d   = ST_HELD_DELAY;
                        event_d   = 1'b1;
                        rep_cnt_d = '0;
                    end
                end
                ST_HELD_DELAY: begin
                    if (REPEAT_EN && (rep_cnt_q == DELAY_LAST)) begin
                        state_d   = ST_REPEATING;
                        event_d   = 1'b1;
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q != '1) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                ST_REPEATING: begin
                    if (rep_cnt_q == PERIOD_LAST) begin
                        event_d   = 1'b1;
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q != '1) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_RELEASED;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RELEASED;
            rep_cnt_q  <= '0;
            key_event  <= 1'b0;
            key_repeat <= 1'b0;
        end else begin
            state_q    <= state_d;
            rep_cnt_q  <= rep_cnt_d;
            key_event  <= event_d;
            key_repeat <= repeat_d;
        end
    end
`else
    // Press-only FSM: a held key parks in HELD_DELAY until released.
    always_comb begin
        state_d = state_q;
        event_d = 1'b0;
        if (fall_c) begin
            state_d = ST_RELEASED;
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    if (rise_c) begin
                        state_d = ST_HELD_DELAY;
                        event_d = 1'b1;
                    end
                end
                ST_HELD_DELAY: begin
                    state_d = ST_HELD_DELAY;
                end
                default: begin
                    state_d = ST_RELEASED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RELEASED;
            key_event <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_event <= event_d;
        end
    end

    assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: N_KEYS independent synchronize/debounce/repeat channels.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat on keys selected by
// REPEAT_MASK; undefined -> press events only, Key_Repeat tied 0).
// Ports:
//   Clk_In : system clock, rising edge
//   Rst_n  : asynchronous active-low reset
//   kbus   : key bus (slave) - Key_Raw in; Key_Level, Key_Event, Key_Repeat out
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned       N_KEYS          = N_KEYS_DEFAULT,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter int unsigned       REPEAT_DELAY    = 25000000,
    parameter int unsigned       REPEAT_PERIOD   = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     =
        N_KEYS'((1 << KEY_LEFT) | (1 << KEY_RIGHT) | (1 << KEY_DOWN))
)(
    input  logic              Clk_In,
    input  logic              Rst_n,
    key_conditioner_if.slave  kbus
);

    // Parameter sanity; an out-of-range setup shows up as a named marker scope.
    localparam bit CFG_BAD =
        (DEBOUNCE_CYCLES == 0) || (DEBOUNCE_CYCLES >= (64'd1 << DEB_W)) ||
        (REPEAT_DELAY    == 0) || (REPEAT_DELAY    >= (64'd1 << REP_W)) ||
        (REPEAT_PERIOD   == 0) || (REPEAT_PERIOD   >= (64'd1 << REP_W)) ||
        ($bits(REPEAT_MASK) != N_KEYS);

    if (CFG_BAD) begin : g_cfg_out_of_range
    end

    logic [N_KEYS-1:0] level_v;
    logic [N_KEYS-1:0] event_v;
    logic [N_KEYS-1:0] repeat_v;

    // One fully independent channel per key.
    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
`ifdef KEY_AUTOREPEAT_EN
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[k])
        ) u_ch (
            .clk        (Clk_In),
            .rst_n      (Rst_n),
            .raw        (kbus.Key_Raw[k]),
            .key_level  (level_v[k]),
            .key_event  (event_v[k]),
            .key_repeat (repeat_v[k])
        );
`else
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (Clk_In),
            .rst_n      (Rst_n),
            .raw        (kbus.Key_Raw[k]),
            .key_level  (level_v[k]),
            .key_event  (event_v[k]),
            .key_repeat (repeat_v[k])
        );
`endif
    end

    assign kbus.Key_Level  = level_v;
    assign kbus.Key_Event  = event_v;
    assign kbus.Key_Repeat = repeat_v;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8, N_KEYS=5. Cycle k is the interval after the k-th rising
// edge following reset release; raw keys are applied in cycle 0.
module tb_key_conditioner;
    import key_pkg::*;

    localparam int unsigned NK  = 5;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 8;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    localparam logic [NK-1:0] M_ROT   = NK'(1 << KEY_ROTATE);
    localparam logic [NK-1:0] M_LEFT  = NK'(1 << KEY_LEFT);
    localparam logic [NK-1:0] M_RIGHT = NK'(1 << KEY_RIGHT);
    localparam logic [NK-1:0] M_DOWN  = NK'(1 << KEY_DOWN);
    localparam logic [NK-1:0] M_PAUSE = NK'(1 << KEY_PAUSE);
    localparam logic [NK-1:0] M_NONE  = '0;

    logic Clk_In = 1'b0;
    logic Rst_n;

    always #5 Clk_In = ~Clk_In;

    key_conditioner_if #(.N_KEYS(NK)) kif ();

    key_conditioner #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (5'b01110)
    ) dut (
        .Clk_In (Clk_In),
        .Rst_n  (Rst_n),
        .kbus   (kif)
    );

    typedef struct {
        string          name;
        logic [NK-1:0]  raw;
        int             hold;
        int             chk;
        logic [NK-1:0]  lvl;
        logic [NK-1:0]  evt;
        logic [NK-1:0]  rpt;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic add(input string name, input logic [NK-1:0] raw, input int hold,
                       input int chk, input logic [NK-1:0] lvl,
                       input logic [NK-1:0] evt, input logic [NK-1:0] rpt);
        vec_t v;
        v.name = name; v.raw = raw; v.hold = hold; v.chk = chk;
        v.lvl = lvl; v.evt = evt; v.rpt = rpt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk_In);
        #1;
        cyc++;
    endtask

    // Reset, release, and stop #1 after the next edge: that point is cycle 0.
    task automatic do_reset();
        kif.Key_Raw = '0;
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk_In);
        #1 Rst_n = 1'b1;
        @(posedge Clk_In);
        #1;
        cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NK-1:0] ar_left;
        logic [NK-1:0] ar_right;
        logic [NK-1:0] ar_lrd;
        int ev;
        int rp;
        int rp_any;
        int nz;

        ar_left  = AR ? M_LEFT  : M_NONE;
        ar_right = AR ? M_RIGHT : M_NONE;
        ar_lrd   = AR ? (M_LEFT | M_RIGHT | M_DOWN) : M_NONE;

        //   name             raw               hold chk  level             event             repeat
        add("reset_state",    M_NONE,            0,   0, M_NONE,           M_NONE,           M_NONE);
        add("left_c5",        M_LEFT,          100,   5, M_NONE,           M_NONE,           M_NONE);
        add("left_press_c6",  M_LEFT,          100,   6, M_LEFT,           M_LEFT,           M_NONE);
        add("left_c7",        M_LEFT,          100,   7, M_LEFT,           M_NONE,           M_NONE);
        add("left_c25",       M_LEFT,          100,  25, M_LEFT,           M_NONE,           M_NONE);
        add("left_rep_c26",   M_LEFT,          100,  26, M_LEFT,           ar_left,          ar_left);
        add("left_c27",       M_LEFT,          100,  27, M_LEFT,           M_NONE,           M_NONE);
        add("left_rep_c34",   M_LEFT,          100,  34, M_LEFT,           ar_left,          ar_left);
        add("left_c41",       M_LEFT,          100,  41, M_LEFT,           M_NONE,           M_NONE);
        add("left_rep_c42",   M_LEFT,          100,  42, M_LEFT,           ar_left,          ar_left);
        add("down_glitch_c6", M_DOWN,            3,   6, M_NONE,           M_NONE,           M_NONE);
        add("down_glitch_c9", M_DOWN,            3,   9, M_NONE,           M_NONE,           M_NONE);
        add("down_min_c6",    M_DOWN,            4,   6, M_DOWN,           M_DOWN,           M_NONE);
        add("down_min_c10",   M_DOWN,            4,  10, M_NONE,           M_NONE,           M_NONE);
        add("rot_right_c6",   M_ROT | M_RIGHT, 100,   6, M_ROT | M_RIGHT,  M_ROT | M_RIGHT,  M_NONE);
        add("rot_right_c26",  M_ROT | M_RIGHT, 100,  26, M_ROT | M_RIGHT,  ar_right,         ar_right);
        add("rot_c26",        M_ROT,           100,  26, M_ROT,            M_NONE,           M_NONE);
        add("pause_c6",       M_PAUSE,         100,   6, M_PAUSE,          M_PAUSE,          M_NONE);
        add("all_c6",         5'b11111,        100,   6, 5'b11111,         5'b11111,         M_NONE);
        add("all_c26",        5'b11111,        100,  26, 5'b11111,         ar_lrd,           ar_lrd);
        add("left_rel_c15",   M_LEFT,           10,  15, M_LEFT,           M_NONE,           M_NONE);
        add("left_rel_c16",   M_LEFT,           10,  16, M_NONE,           M_NONE,           M_NONE);
        add("rel_due_c33",    M_LEFT,           28,  33, M_LEFT,           M_NONE,           M_NONE);
        add("rel_due_c34",    M_LEFT,           28,  34, M_NONE,           M_NONE,           M_NONE);

        foreach (vecs[i]) begin
            do_reset();
            kif.Key_Raw = vecs[i].raw;
            while (cyc < vecs[i].chk) begin
                step();
                if (cyc == vecs[i].hold) kif.Key_Raw = '0;
            end
            check($sformatf("%s.level",  vecs[i].name), kif.Key_Level,  vecs[i].lvl);
            check($sformatf("%s.event",  vecs[i].name), kif.Key_Event,  vecs[i].evt);
            check($sformatf("%s.repeat", vecs[i].name), kif.Key_Repeat, vecs[i].rpt);
        end

        // Rotate held 100 cycles: a single press event, never a repeat.
        do_reset();
        kif.Key_Raw = M_ROT;
        ev = 0; rp = 0;
        while (cyc < 110) begin
            step();
            if (cyc == 100) kif.Key_Raw = '0;
            if (kif.Key_Event[KEY_ROTATE])  ev++;
            if (kif.Key_Repeat[KEY_ROTATE]) rp++;
        end
        check_int("rotate_hold.events",  ev, 1);
        check_int("rotate_hold.repeats", rp, 0);

        // Left held 60 cycles: press at 6, repeats 26..58, the one due at release (66) dropped.
        do_reset();
        kif.Key_Raw = M_LEFT;
        ev = 0; rp = 0; rp_any = 0;
        while (cyc < 80) begin
            step();
            if (cyc == 60) kif.Key_Raw = '0;
            if (kif.Key_Event[KEY_LEFT])  ev++;
            if (kif.Key_Repeat[KEY_LEFT]) rp++;
            if (kif.Key_Repeat != '0)     rp_any++;
        end
        check_int("left_hold60.events",  ev, AR ? 6 : 1);
        check_int("left_hold60.repeats", rp, AR ? 5 : 0);
        check_int("left_hold60.any_repeat_cycles", rp_any, AR ? 5 : 0);

        // Reset in cycles 30..34 while Left is held; fresh press expected at cycle 41.
        do_reset();
        kif.Key_Raw = M_LEFT;
        while (cyc < 30) step();
        check("mid_reset.level_before", kif.Key_Level, M_LEFT);
        Rst_n = 1'b0;
        #1;
        check("mid_reset.level_async",  kif.Key_Level,  M_NONE);
        check("mid_reset.event_async",  kif.Key_Event,  M_NONE);
        check("mid_reset.repeat_async", kif.Key_Repeat, M_NONE);
        nz = 0;
        while (cyc < 35) begin
            step();
            if ((kif.Key_Level | kif.Key_Event | kif.Key_Repeat) != '0) nz++;
        end
        check_int("mid_reset.outputs_during_reset", nz, 0);
        Rst_n = 1'b1;
        ev = 0;
        while (cyc < 40) begin
            step();
            if (kif.Key_Event != '0) ev++;
        end
        check_int("mid_reset.early_events", ev, 0);
        check("mid_reset.level_c40", kif.Key_Level, M_NONE);
        step();
        check("mid_reset.level_c41",  kif.Key_Level,  M_LEFT);
        check("mid_reset.event_c41",  kif.Key_Event,  M_LEFT);
        check("mid_reset.repeat_c41", kif.Key_Repeat, M_NONE);
        kif.Key_Raw = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
